onchip_sram_dp_pipelined: RTL and testbench

Parametrised true-dual-port on-chip SRAM with two independent Avalon-MM pipelined slaves (s1, s2). It replaces the fixed 16K×32 two-slave on-chip memory in the Computer_System fabric. It adds:
- configurable width, depth and read latency;
- readdatavalid/waitrequest handshaking;
- deterministic same-address write-collision resolution with a collision counter;
- a hardware zero-fill engine that runs on reset and on request, so radar frame buffers start from a known state.

---
 rtl/onchip_sram_dp_pipelined_pkg.sv | 21 ++
 rtl/onchip_sram_dp_pipelined_if.sv | 26 ++
 rtl/onchip_sram_dp_pipelined_core.sv | 38 +++
 rtl/onchip_sram_dp_pipelined.sv | 156 +++++++++++++++
 tb/tb_onchip_sram_dp_pipelined.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/onchip_sram_dp_pipelined_pkg.sv
// Shared types and constants for the dual-port pipelined on-chip SRAM.
// Holds the clear-engine state type, the collision counter width and the
// legal read-latency range with a helper used at elaboration.
package sram_dp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      READY
   } clear_state_t;

   localparam int COLL_CNT_W = 16;

   localparam int READ_LATENCY_MIN = 1;
   localparam int READ_LATENCY_MAX = 2;

   function automatic bit read_latency_ok(input int rl);
      return (rl >= READ_LATENCY_MIN) && (rl <= READ_LATENCY_MAX);
   endfunction

endpackage

// File: rtl/onchip_sram_dp_pipelined_if.sv
// Avalon-MM pipelined slave bundle: one instance per memory port.
// The master drives address/commands/write data; the slave answers with
// waitrequest and the readdata/readdatavalid return path.
interface onchip_sram_dp_pipelined_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14
);
   logic [ADDR_W-1:0]   address;
   logic                read;
   logic                write;
   logic [DATA_W/8-1:0] byteenable;
   logic [DATA_W-1:0]   writedata;
   logic                waitrequest;
   logic [DATA_W-1:0]   readdata;
   logic                readdatavalid;

   modport master (
      output address, read, write, byteenable, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, read, write, byteenable, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/onchip_sram_dp_pipelined_core.sv
// True-dual-port byte-enabled array with one registered read per port.
// Read data appears one clock after the read enable; a read and a write to
// the same word on opposite ports in the same cycle returns the old word.
module sram_dp_core #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 14
) (
   input  logic                clk,
   input  logic                a_re,
   input  logic                a_we,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [DATA_W/8-1:0] a_be,
   input  logic [DATA_W-1:0]   a_wdata,
   output logic [DATA_W-1:0]   a_rdata,
   input  logic                b_re,
   input  logic                b_we,
   input  logic [ADDR_W-1:0]   b_addr,
   input  logic [DATA_W/8-1:0] b_be,
   input  logic [DATA_W-1:0]   b_wdata,
   output logic [DATA_W-1:0]   b_rdata
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int BE_W  = DATA_W / 8;

   logic [DATA_W-1:0] mem [DEPTH];

   // Reads sample the pre-edge contents (old data); writes update enabled lanes.
   // The caller never enables both writes to the same word in one cycle.
   always_ff @(posedge clk) begin
      if (a_re) a_rdata <= mem[a_addr];
      if (b_re) b_rdata <= mem[b_addr];
      for (int i = 0; i < BE_W; i++) begin
         if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
         if (b_we && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      end
   end

endmodule

// File: rtl/onchip_sram_dp_pipelined.sv
// Dual Avalon-MM pipelined slave SRAM with zero-fill engine and collision counter.
// Read data returns READ_LATENCY cycles after the array read, in order, one per cycle.
// Both ports hold waitrequest while the fill engine owns port A; otherwise never stall.
module onchip_sram_dp_pipelined
   import sram_dp_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 14,
   parameter int READ_LATENCY   = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                        clk,
   input  logic                        reset,
   onchip_sram_dp_pipelined_if.slave   s1,
   onchip_sram_dp_pipelined_if.slave   s2,
   input  logic                        clear_req,
   output logic                        busy,
   output logic [COLL_CNT_W-1:0]       collision_count
);
   localparam int BE_W = DATA_W / 8;

   if (!read_latency_ok(READ_LATENCY)) begin : g_bad_read_latency
      $error("READ_LATENCY must be 1 or 2");
   end

   clear_state_t      state;
   logic [ADDR_W-1:0] ptr;

   // Accepted requests; simultaneous read+write counts as a write.
   logic s1_wr, s1_rd, s2_wr, s2_rd, collide;
   assign s1_wr   = s1.write && !busy;
   assign s1_rd   = s1.read && !s1.write && !busy;
   assign s2_wr   = s2.write && !busy;
   assign s2_rd   = s2.read && !s2.write && !busy;
   assign collide = s1_wr && s2_wr && (s1.address == s2.address);

   assign s1.waitrequest = busy;
   assign s2.waitrequest = busy;

   // Port A is shared between the fill engine and s1; s1 cannot be accepted in CLEAR.
   logic                clearing;
   logic                a_we;
   logic [ADDR_W-1:0]   a_addr;
   logic [BE_W-1:0]     a_be;
   logic [DATA_W-1:0]   a_wdata;
   logic [DATA_W-1:0]   a_rdata, b_rdata;

   assign clearing = (state == CLEAR);
   assign a_we     = clearing || s1_wr;
   assign a_addr   = clearing ? ptr : s1.address;
   assign a_be     = clearing ? {BE_W{1'b1}} : s1.byteenable;
   assign a_wdata  = clearing ? '0 : s1.writedata;

   sram_dp_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk     (clk),
      .a_re    (s1_rd),
      .a_we    (a_we),
      .a_addr  (a_addr),
      .a_be    (a_be),
      .a_wdata (a_wdata),
      .a_rdata (a_rdata),
      .b_re    (s2_rd),
      .b_we    (s2_wr && !collide),
      .b_addr  (s2.address),
      .b_be    (s2.byteenable),
      .b_wdata (s2.writedata),
      .b_rdata (b_rdata)
   );

   // Clear FSM: boot into CLEAR or READY, sweep every word once, busy registered with state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
         busy  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               ptr <= '0;
               if (CLEAR_ON_RESET) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
               end else begin
                  state <= READY;
                  busy  <= 1'b0;
               end
            end
            CLEAR: begin
               ptr <= ptr + 1'b1;
               if (&ptr) begin
                  state <= READY;
                  busy  <= 1'b0;
               end
            end
            READY: begin
               if (clear_req) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
                  ptr   <= '0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   // Saturating count of same-address dual writes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         collision_count <= '0;
      else if (collide && (collision_count != {COLL_CNT_W{1'b1}}))
         collision_count <= collision_count + 1'b1;
   end

   // Return pipelines: array read flag, then READ_LATENCY output stages per port.
   logic                                 rd1_q, rd2_q;
   logic [READ_LATENCY-1:0]              v1, v2;
   logic [READ_LATENCY-1:0][DATA_W-1:0]  d1, d2;

   // Shift valid flags and read data; reset discards anything in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd1_q <= 1'b0;
         rd2_q <= 1'b0;
         v1    <= '0;
         v2    <= '0;
         d1    <= '0;
         d2    <= '0;
      end else begin
         rd1_q <= s1_rd;
         rd2_q <= s2_rd;
         v1[0] <= rd1_q;
         v2[0] <= rd2_q;
         if (rd1_q) d1[0] <= a_rdata;
         if (rd2_q) d2[0] <= b_rdata;
         for (int i = 1; i < READ_LATENCY; i++) begin
            v1[i] <= v1[i-1];
            v2[i] <= v2[i-1];
            d1[i] <= d1[i-1];
            d2[i] <= d2[i-1];
         end
      end
   end

   assign s1.readdatavalid = v1[READ_LATENCY-1];
   assign s1.readdata      = d1[READ_LATENCY-1];
   assign s2.readdatavalid = v2[READ_LATENCY-1];
   assign s2.readdata      = d2[READ_LATENCY-1];

endmodule

// File: tb/tb_onchip_sram_dp_pipelined.sv
// Bench for onchip_sram_dp_pipelined: 16-word array, READ_LATENCY=2, fill on reset.
// A word-level model predicts busy, returns and collisions every cycle; directed
// cases pin the model with hand-computed literal values.
module tb_onchip_sram_dp_pipelined;
   localparam int DW    = 32;
   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int RL    = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clear_req = 1'b0;
   logic busy;
   logic [15:0] cc;

   always #5 clk = ~clk;

   onchip_sram_dp_pipelined_if #(.DATA_W(DW), .ADDR_W(AW)) s1 ();
   onchip_sram_dp_pipelined_if #(.DATA_W(DW), .ADDR_W(AW)) s2 ();

   onchip_sram_dp_pipelined #(
      .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(RL), .CLEAR_ON_RESET(1'b1)
   ) dut (
      .clk(clk), .reset(rst), .s1(s1), .s2(s2),
      .clear_req(clear_req), .busy(busy), .collision_count(cc)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int due; logic [DW-1:0] d; } exp_t;
   exp_t q1[$], q2[$];
   logic [DW-1:0] mmem [DEPTH];
   int   m_left = DEPTH + 1;   // edges of busy remaining: one boot edge + DEPTH fill edges
   int   ecount = 0;
   logic [15:0] mcc = '0;
   bit   mw1, mw2, mr1, mr2, mcoll;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_left = DEPTH + 1;
         q1.delete();
         q2.delete();
         mcc = '0;
      end else begin
         ecount++;
         if (m_left == 0) begin
            mw1 = s1.write;
            mw2 = s2.write;
            mr1 = s1.read && !s1.write;
            mr2 = s2.read && !s2.write;
            mcoll = mw1 && mw2 && (s1.address == s2.address);
            if (mr1) q1.push_back('{ecount + RL, mmem[s1.address]});
            if (mr2) q2.push_back('{ecount + RL, mmem[s2.address]});
            for (int b = 0; b < DW/8; b++) begin
               if (mw1 && s1.byteenable[b]) mmem[s1.address][b*8 +: 8] = s1.writedata[b*8 +: 8];
               if (mw2 && !mcoll && s2.byteenable[b]) mmem[s2.address][b*8 +: 8] = s2.writedata[b*8 +: 8];
            end
            if (mcoll && mcc != 16'hFFFF) mcc++;
            if (clear_req) m_left = DEPTH;
         end else begin
            if (m_left <= DEPTH) mmem[DEPTH - m_left] = '0;
            m_left--;
         end
      end
   end

   // Compare every cycle on the falling edge.
   bit ev1, ev2;
   always @(negedge clk) begin
      ev1 = (q1.size() > 0) && (q1[0].due == ecount);
      ev2 = (q2.size() > 0) && (q2[0].due == ecount);
      chk("s1_readdatavalid", s1.readdatavalid, ev1);
      chk("s2_readdatavalid", s2.readdatavalid, ev2);
      if (ev1) begin chk("s1_readdata", s1.readdata, q1[0].d); void'(q1.pop_front()); end
      if (ev2) begin chk("s2_readdata", s2.readdata, q2[0].d); void'(q2.pop_front()); end
      chk("busy", busy, m_left > 0);
      chk("s1_waitrequest", s1.waitrequest, m_left > 0);
      chk("s2_waitrequest", s2.waitrequest, m_left > 0);
      chk("collision_count", cc, mcc);
   end

   // Log of returned s1/s2 data with the edge count at which they showed up.
   typedef struct { int cyc; logic [DW-1:0] d; } log_t;
   log_t log1[$], log2[$];
   int ncyc = 0;
   always @(posedge clk) ncyc++;
   always @(negedge clk) begin
      if (s1.readdatavalid === 1'b1) log1.push_back('{ncyc, s1.readdata});
      if (s2.readdatavalid === 1'b1) log2.push_back('{ncyc, s2.readdata});
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      s1.read = 0; s1.write = 0; s2.read = 0; s2.write = 0; clear_req = 0;
   endtask

   task automatic set1(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [DW-1:0] d);
      s1.read = rd; s1.write = wr; s1.address = a; s1.byteenable = be; s1.writedata = d;
   endtask

   task automatic set2(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [3:0] be, input logic [DW-1:0] d);
      s2.read = rd; s2.write = wr; s2.address = a; s2.byteenable = be; s2.writedata = d;
   endtask

   // s1 read with literal data and latency check; other s2 settings ride along for one edge.
   task automatic rd_s1(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string nm);
      int n0, k;
      set1(1, 0, a, 4'h0, '0);
      tick();
      idle_all();
      n0 = ncyc;
      k = 0;
      @(negedge clk);
      while (s1.readdatavalid !== 1'b1 && k < 20) begin k++; @(negedge clk); end
      if (k >= 20) chk({nm, "_timeout"}, 0, 1);
      else begin
         chk(nm, s1.readdata, exp);
         chk({nm, "_latency"}, ncyc - n0, RL);
      end
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
   endtask

   task automatic read_all_zero(input string nm);
      logic [DW-1:0] orv;
      log1.delete(); log2.delete();
      for (int i = 0; i < DEPTH; i++) begin
         set1(1, 0, AW'(i), 4'h0, '0);
         set2(1, 0, AW'(DEPTH-1-i), 4'h0, '0);
         tick();
      end
      idle_all();
      repeat (RL + 3) tick();
      orv = '0;
      foreach (log1[i]) orv |= log1[i].d;
      foreach (log2[i]) orv |= log2[i].d;
      chk({nm, "_count_s1"}, log1.size(), DEPTH);
      chk({nm, "_count_s2"}, log2.size(), DEPTH);
      chk({nm, "_or"}, orv, 0);
   endtask

   int n;

   initial begin
      idle_all();
      set1(0, 0, '0, 4'h0, '0);
      set2(0, 0, '0, 4'h0, '0);

      // Reset values.
      @(negedge clk);
      chk("rst_busy", busy, 1);
      chk("rst_wait_s1", s1.waitrequest, 1);
      chk("rst_wait_s2", s2.waitrequest, 1);
      chk("rst_vld_s1", s1.readdatavalid, 0);
      chk("rst_data_s1", s1.readdata, 0);
      chk("rst_data_s2", s2.readdata, 0);
      chk("rst_cc", cc, 0);

      // Boot fill: one IDLE cycle then DEPTH CLEAR cycles.
      @(posedge clk); #1;
      rst = 0;
      wait_ready(n);
      chk("boot_busy_cycles", n, DEPTH + 1);
      read_all_zero("boot_reads");

      // Back-to-back reads of 0..7 on both ports after distinct writes.
      for (int i = 0; i < 8; i++) begin
         set1(0, 1, AW'(i), 4'hF, 32'h100 + i);
         set2(0, 1, AW'(i + 8), 4'hF, 32'h200 + i);
         tick();
      end
      idle_all();
      log1.delete(); log2.delete();
      for (int i = 0; i < 8; i++) begin
         set1(1, 0, AW'(i), 4'h0, '0);
         set2(1, 0, AW'(i), 4'h0, '0);
         tick();
      end
      idle_all();
      repeat (RL + 3) tick();
      chk("b2b_count", log1.size(), 8);
      if (log1.size() == 8 && log2.size() == 8) begin
         chk("b2b_first", log1[0].d, 32'h100);
         chk("b2b_last", log2[7].d, 32'h107);
         chk("b2b_span", log1[7].cyc - log1[0].cyc, 7);
      end

      // Byte-lane merge across ports.
      set1(0, 1, 4'd5, 4'hF, 32'hDEADBEEF); tick();
      idle_all();
      set2(0, 1, 4'd5, 4'h1, 32'h000000AA); tick();
      idle_all();
      rd_s1(4'd5, 32'hDEADBEAA, "merge5");

      // Same-address collision: s1 wins.
      set1(0, 1, 4'd7, 4'hF, 32'h11111111);
      set2(0, 1, 4'd7, 4'hF, 32'h22222222);
      tick();
      idle_all();
      rd_s1(4'd7, 32'h11111111, "coll7");
      chk("coll_cnt_1", cc, 1);

      // Mixed-port read-during-write returns old data.
      set1(0, 1, 4'd3, 4'hF, 32'h5); tick();
      idle_all();
      set2(0, 1, 4'd3, 4'hF, 32'h9);
      rd_s1(4'd3, 32'h5, "rdw_old");
      rd_s1(4'd3, 32'h9, "rdw_new");

      // Different addresses: no collision; partial byte enables.
      set1(0, 1, 4'd8, 4'hF, 32'hAA);
      set2(0, 1, 4'd9, 4'hF, 32'hBB);
      tick();
      idle_all();
      chk("no_coll_cnt", cc, 1);
      set1(0, 1, 4'd9, 4'h5, 32'h12345678); tick();
      idle_all();
      rd_s1(4'd9, 32'h00340078, "lanes9");

      // clear_req during streaming writes; s2 read on the same edge still returns.
      for (int i = 0; i < 6; i++) begin
         set1(0, 1, AW'(i), 4'hF, 32'hA0 + i);
         set2(1, 0, AW'(i), 4'h0, '0);
         clear_req = (i == 3);
         tick();
      end
      idle_all();
      set2(0, 1, 4'd12, 4'hF, 32'hFFFF);
      repeat (5) tick();
      idle_all();
      chk("mid_clear_busy", busy, 1);
      rst = 1;
      tick(); tick();
      chk("rst_mid_clear_busy", busy, 1);
      rst = 0;
      clear_req = 1;
      tick();
      clear_req = 0;
      wait_ready(n);
      chk("refill_busy_cycles", n, DEPTH);
      read_all_zero("refill_reads");

      // Reset while a read is in flight discards its return.
      log1.delete();
      set1(1, 0, 4'd2, 4'h0, '0);
      tick();
      idle_all();
      rst = 1;
      repeat (RL + 2) tick();
      chk("rst_drop_read", log1.size(), 0);
      rst = 0;
      wait_ready(n);
      chk("final_busy_cycles", n, DEPTH + 1);
      repeat (2) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
